// File: rtl/prog_clock_divider.sv
// Programmable clock divider: periodic tick, square wave and one-shot modes.
// The divisor and mode are latched by load; the counter runs on enabled cycles.
module prog_clock_divider #(
    parameter int                     COUNT_WIDTH  = 24,
    parameter logic [COUNT_WIDTH-1:0] DEFAULT_DIV  = COUNT_WIDTH'(6000000 - 1),
    parameter logic [1:0]             DEFAULT_MODE = 2'b00
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   load,
    input  logic [COUNT_WIDTH-1:0] div_in,
    input  logic [1:0]             mode_in,
    input  logic                   start,
    output logic                   tick,
    output logic                   sq,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] count
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [COUNT_WIDTH-1:0] r_div;
    logic [1:0]             r_mode;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] w_count_nxt;
    logic                   r_tick;
    logic                   r_sq;
    logic                   w_tick_nxt;
    logic                   w_sq_nxt;
    logic                   w_oneshot;
    logic                   w_active;
    logic                   w_tc;

    // Mode 11 falls through to periodic behaviour because only 10 is special.
    assign w_oneshot = (r_mode == MODE_ONESHOT);
    assign w_active  = en && (!w_oneshot || (r_state == ST_RUN));
    assign w_tc      = w_active && (r_count == r_div);

    always_comb begin
        w_count_nxt = r_count;
        w_tick_nxt  = 1'b0;
        w_sq_nxt    = r_sq;
        w_state_nxt = r_state;
        if (load) begin
            // load wins over a coincident terminal count: no tick, sq holds
            w_count_nxt = '0;
            w_state_nxt = ST_IDLE;
        end else if (w_tc) begin
            w_count_nxt = '0;
            w_tick_nxt  = 1'b1;
            w_sq_nxt    = ~r_sq;
            w_state_nxt = ST_IDLE;
        end else if (w_active) begin
            w_count_nxt = r_count + COUNT_WIDTH'(1);
        end else if (w_oneshot && (r_state == ST_IDLE) && en && start) begin
            w_count_nxt = '0;
            w_state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div  <= DEFAULT_DIV;
            r_mode <= DEFAULT_MODE;
        end else if (load) begin
            r_div  <= div_in;
            r_mode <= mode_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_tick  <= 1'b0;
            r_sq    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_tick  <= w_tick_nxt;
            r_sq    <= w_sq_nxt;
        end
    end

    assign busy  = w_oneshot ? (r_state == ST_RUN) : en;
    assign tick  = r_tick;
    assign sq    = r_sq;
    assign count = r_count;

endmodule
